// File: rtl/elastic_unshift.sv
// Two-entry skid buffer that decodes left-shifted-by-2 words back to their natural form
// and flags words whose two low bits were not zero. Also counts delivered and errored words.
module elastic_unshift #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstf,
    input  logic [WIDTH-1:0] t0_data,
    input  logic             t0_valid,
    output logic             t0_ready,
    output logic [WIDTH-1:0] i0_data,
    output logic             i0_err,
    output logic             i0_valid,
    input  logic             i0_ready,
    input  logic             clr,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_err_q, out_err_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             skid_err_q, skid_err_d;
    logic             t0_ready_q, t0_ready_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [WIDTH-1:0] dec_data;
    logic             dec_err;
    logic             valid_w;
    logic             t0_xfer;
    logic             i0_xfer;

    assign dec_data = {2'b00, t0_data[WIDTH-1:2]};
    assign dec_err  = t0_data[1] | t0_data[0];
    assign valid_w  = (state_q == S_ONE) || (state_q == S_FULL);
    assign t0_xfer  = t0_valid & t0_ready_q;
    assign i0_xfer  = valid_w & i0_ready;

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;
        unique case (state_q)
            S_EMPTY: begin
                if (t0_xfer) begin
                    out_data_d = dec_data;
                    out_err_d  = dec_err;
                    state_d    = S_ONE;
                end
            end
            S_ONE: begin
                if (t0_xfer && i0_xfer) begin
                    out_data_d = dec_data;
                    out_err_d  = dec_err;
                end else if (t0_xfer) begin
                    skid_data_d = dec_data;
                    skid_err_d  = dec_err;
                    state_d     = S_FULL;
                end else if (i0_xfer) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (i0_xfer) begin
                    out_data_d = skid_data_q;
                    out_err_d  = skid_err_q;
                    state_d    = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        // Ready is registered from the next state so it never depends on i0_ready combinationally.
        t0_ready_d = (state_d != S_FULL);
    end

    always_comb begin
        word_cnt_d = word_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (clr) begin
            word_cnt_d = '0;
            err_cnt_d  = '0;
        end else if (i0_xfer) begin
            if (!(&word_cnt_q)) word_cnt_d = word_cnt_q + 1'b1;
            if (out_err_q && !(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            state_q     <= S_EMPTY;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
            t0_ready_q  <= 1'b0;
            word_cnt_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
            t0_ready_q  <= t0_ready_d;
            word_cnt_q  <= word_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign t0_ready = t0_ready_q;
    assign i0_valid = valid_w;
    assign i0_data  = out_data_q;
    assign i0_err   = out_err_q;
    assign word_cnt = word_cnt_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_elastic_unshift.sv
// Scoreboard bench for elastic_unshift: a default instance plus a 2-bit-counter instance
// sharing the same stimulus, used for counter saturation.
module tb_elastic_unshift;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rstf = 1'b1;
    logic [W-1:0] t0_data = '0;
    logic         t0_valid = 1'b0;
    logic         i0_ready = 1'b0;
    logic         clr = 1'b0;
    logic         t0_ready, i0_err, i0_valid;
    logic [W-1:0] i0_data;
    logic [15:0]  word_cnt, err_cnt;
    logic         s_t0_ready, s_i0_err, s_i0_valid;
    logic [W-1:0] s_i0_data;
    logic [1:0]   s_word_cnt, s_err_cnt;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [W-1:0] d;
        logic         e;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    elastic_unshift #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .rstf(rstf), .t0_data(t0_data), .t0_valid(t0_valid), .t0_ready(t0_ready),
        .i0_data(i0_data), .i0_err(i0_err), .i0_valid(i0_valid), .i0_ready(i0_ready),
        .clr(clr), .word_cnt(word_cnt), .err_cnt(err_cnt)
    );

    elastic_unshift #(.WIDTH(W), .CNT_W(2)) dut_s (
        .clk(clk), .rstf(rstf), .t0_data(t0_data), .t0_valid(t0_valid), .t0_ready(s_t0_ready),
        .i0_data(s_i0_data), .i0_err(s_i0_err), .i0_valid(s_i0_valid), .i0_ready(i0_ready),
        .clr(clr), .word_cnt(s_word_cnt), .err_cnt(s_err_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on accepted input, pop and compare on delivered output.
    always @(negedge clk) begin
        if (rstf) begin
            if (t0_valid && t0_ready)
                sb.push_back('{d: t0_data >> 2, e: (t0_data[1:0] != 2'b00)});
            if (i0_valid && i0_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", i0_data, 64'hdead);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    check("out_data", i0_data, x.d);
                    check("out_err", i0_err, x.e);
                    check("s_out_data", s_i0_data, x.d);
                    check("s_out_valid", s_i0_valid, 1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, output int stalls);
        int n;
        n = 0;
        t0_data  = d;
        t0_valid = 1'b1;
        @(negedge clk);
        while (!t0_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!t0_ready) check("send_timeout", t0_ready, 1);
        stalls = n;
        @(posedge clk);
        #1;
        t0_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int tot_stalls;
        int exp_err;
        logic [W-1:0] w;

        // reset state
        #1 rstf = 1'b0;
        #1;
        check("rst_t0_ready", t0_ready, 0);
        check("rst_i0_valid", i0_valid, 0);
        check("rst_i0_data", i0_data, 0);
        check("rst_i0_err", i0_err, 0);
        check("rst_word_cnt", word_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstf = 1'b1;
        #1;
        check("rel_t0_ready_pre", t0_ready, 0);
        tick();
        check("rel_t0_ready", t0_ready, 1);

        // single word with one-cycle latency
        i0_ready = 1'b1;
        send(32'h0000_0040, st);
        check("lat_valid", i0_valid, 1);
        check("lat_data", i0_data, 32'h0000_0010);
        check("lat_err", i0_err, 0);
        wait_drain();
        check("single_word_cnt", word_cnt, 1);
        check("single_err_cnt", err_cnt, 0);

        // error word
        clr = 1'b1;
        tick();
        clr = 1'b0;
        send(32'h0000_0043, st);
        check("err_flag", i0_err, 1);
        check("err_data", i0_data, 32'h0000_0010);
        wait_drain();
        check("err_word_cnt", word_cnt, 1);
        check("err_err_cnt", err_cnt, 1);

        // backpressure: 4 and 8 fill the buffer, 12 waits
        i0_ready = 1'b0;
        send(32'd4, st);
        send(32'd8, st);
        check("bp_full_ready", t0_ready, 0);
        t0_data  = 32'd12;
        t0_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_ready", t0_ready, 0);
            check("bp_hold_data", i0_data, 1);
            check("bp_hold_valid", i0_valid, 1);
        end
        i0_ready = 1'b1;
        send(32'd12, st);
        wait_drain();

        // saturation on the 2-bit instance, all error words
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 5; i++) send(32'(i * 4 + 1), st);
        wait_drain();
        check("sat_word_cnt", s_word_cnt, 3);
        check("sat_err_cnt", s_err_cnt, 3);
        check("nosat_word_cnt", word_cnt, 5);
        check("nosat_err_cnt", err_cnt, 5);

        // clr wins over a simultaneous delivery
        i0_ready = 1'b0;
        send(32'h0000_0081, st);
        clr = 1'b1;
        i0_ready = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_word_cnt", word_cnt, 0);
        check("clr_err_cnt", err_cnt, 0);
        check("clr_s_word_cnt", s_word_cnt, 0);
        check("clr_s_err_cnt", s_err_cnt, 0);
        check("clr_sb_empty", sb.size(), 0);

        // streaming 100 random words
        tot_stalls = 0;
        exp_err = 0;
        for (int i = 0; i < 100; i++) begin
            w = $urandom;
            if (w[1:0] != 2'b00) exp_err++;
            send(w, st);
            tot_stalls += st;
        end
        check("stream_stalls", tot_stalls, 0);
        wait_drain();
        check("stream_word_cnt", word_cnt, 100);
        check("stream_err_cnt", err_cnt, exp_err);

        // reset asserted while FULL
        i0_ready = 1'b0;
        send(32'h0000_0100, st);
        send(32'h0000_0200, st);
        check("mid_full_ready", t0_ready, 0);
        rstf = 1'b0;
        #1;
        check("mid_t0_ready", t0_ready, 0);
        check("mid_i0_valid", i0_valid, 0);
        check("mid_i0_data", i0_data, 0);
        check("mid_i0_err", i0_err, 0);
        check("mid_word_cnt", word_cnt, 0);
        check("mid_err_cnt", err_cnt, 0);
        sb.delete();
        repeat (2) tick();
        rstf = 1'b1;
        tick();
        check("mid_rel_ready", t0_ready, 1);
        i0_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("mid_no_stale", i0_valid, 0);
        end
        check("end_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
